ring_seq_monitor: RTL and testbench
===================================

RING_SEQ_MONITOR -- requirements
Module: ring_seq_monitor

Interface
REQ-001 SHALL have parameter N, default 4, counter width under observation; N >= 2.
REQ-002 SHALL have parameter LOCK_CNT, default 3, number of consecutive correct legal samples needed to declare lock; 1..15.
REQ-003 SHALL have parameter ERR_W, default 8, error counter width.
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset, synchronous, active-low.
REQ-006 SHALL have port en, input, 1, sample strobe; high means q holds a new counter value.
REQ-007 SHALL have port mode, input, 1, 0 = ring (one-hot) sequence, 1 = Johnson (twisted-ring) sequence.
REQ-008 SHALL have port q, input, N, observed output of the upstream ring/Johnson counter.
REQ-009 SHALL have port clr_err, input, 1, synchronous clear of err_cnt.
REQ-010 SHALL have port phase, output, PW = $clog2(2*N), decoded phase index of the last legal sample.
REQ-011 SHALL have port phase_valid, output, 1, last sample was legal.
REQ-012 SHALL have port locked, output, 1, sequence is tracking correctly.
REQ-013 SHALL have port err_pulse, output, 1, one-cycle flag for a sequence error while locked.
REQ-014 SHALL have port err_cnt, output, ERR_W, saturating error count.

Function
REQ-015 SHALL classify ring legality as exactly one bit of q set; phase = index of that bit; period P = N.
REQ-016 SHALL classify Johnson legality as q = 0..01..1 or 1..10..0 (including all-zeros and all-ones); phase = popcount(q) if q[N-1]=0, else 2N - popcount(q); period P = 2N.
REQ-017 SHALL register all outputs; each output reflects the sample taken on the en cycle one clock later (latency 1); without en, all outputs hold, except err_pulse.
REQ-018 SHALL implement FSM states ACQ and LOCKED, plus a good-sample counter gcnt and an expected-phase register exp.
REQ-019 In ACQ on en: legal and (gcnt = 0 or phase = exp) -> gcnt+1 and exp = (phase+1) mod P; illegal -> gcnt = 0; legal mismatch -> gcnt = 1 and exp reseeded from phase.
REQ-020 SHALL move ACQ -> LOCKED on the sample where gcnt reaches LOCK_CNT; locked rises one cycle later.
REQ-021 In LOCKED on en: legal and phase = exp -> stay and advance exp; otherwise err_pulse = 1 for one cycle, err_cnt increments, the FSM enters ACQ with gcnt = 0.
REQ-022 SHALL wrap exp from P-1 to 0; the P-1 -> 0 transition is correct.
REQ-023 SHALL saturate err_cnt at 2^ERR_W - 1; further errors still pulse err_pulse.
REQ-024 SHALL load err_cnt with 1 when clr_err and an error coincide; with clr_err alone, err_cnt is loaded with 0.
REQ-025 SHALL treat any change of mode (vs. the previous cycle) as a forced return to ACQ with gcnt = 0 and no error counted; a sample in that same cycle is ignored.
REQ-026 SHALL set phase_valid = 0 and hold phase at its last legal value on an illegal sample.

Reset
REQ-027 With rst_n low at a clock edge, SHALL set: state ACQ; gcnt = 0; exp = 0; phase = 0; phase_valid = 0; locked = 0; err_pulse = 0; err_cnt = 0.
REQ-028 SHALL apply reset mid-operation, including while LOCKED, with no error counted; en, mode and clr_err are ignored in the reset cycle.

Configuration
REQ-029 With macro RING_SEQ_MON_ERR_CNT_EN defined, SHALL implement err_cnt as above.
REQ-030 Without RING_SEQ_MON_ERR_CNT_EN, SHALL keep the err_cnt port but tie it to 0, ignore clr_err, and remove the counter logic; err_pulse is unaffected.

Structure
REQ-031 SHALL place the FSM state enum (ACQ, LOCKED) and the mode constants (MODE_RING = 0, MODE_JOHNSON = 1) in package ring_mon_pkg.
REQ-032 SHALL put the combinational legality and phase decode in sub-module ring_phase_dec (parameters N; inputs q and mode; outputs legal and phase).

Verification (N = 4, LOCK_CNT = 3, ERR_W = 8)
REQ-033 Ring, en every cycle, q = 0001,0010,0100 -> locked = 1 one cycle after the third sample; phase = 2.
REQ-034 Johnson, locked, sequence 1000 -> 0000 -> phase 7 then phase 0, no err_pulse; eight-step wrap-around is clean.
REQ-035 Locked ring, inject q = 0110 -> err_pulse one cycle, err_cnt = 1, locked = 0, phase_valid = 0; three further legal samples -> locked = 1.
REQ-036 Locked Johnson, skip from phase 2 (0011) to phase 4 (1111) -> err_pulse, err_cnt increments, gcnt = 1; relock after two more correct samples.
REQ-037 Preload err_cnt = 255, inject an error -> err_cnt stays 255, err_pulse = 1; clr_err with a coincident error -> err_cnt = 1.
REQ-038 Pull rst_n low for one cycle while locked -> all outputs equal the REQ-027 values on the next cycle; toggle mode while locked -> locked = 0, err_cnt unchanged.

Source files
------------

// File: rtl/ring_mon_pkg.sv
// Shared types and constants for the ring/Johnson sequence monitor.
package ring_mon_pkg;

  typedef enum logic {
    ACQ    = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam logic MODE_RING    = 1'b0;
  localparam logic MODE_JOHNSON = 1'b1;

  // Wide enough for any LOCK_CNT in 1..15.
  localparam int GCNT_W = 4;

endpackage

// File: rtl/ring_phase_dec.sv
// Combinational legality check and phase decode of one ring or Johnson counter sample.
module ring_phase_dec
  import ring_mon_pkg::*;
#(
  parameter  int N  = 4,
  localparam int PW = $clog2(2 * N)
) (
  input  logic [N-1:0]  q,
  input  logic          mode,
  output logic          legal,
  output logic [PW-1:0] phase
);

  logic [PW-1:0] ones;
  logic [PW-1:0] idx;
  logic [PW:0]   jn_back;
  logic          seen_edge;
  logic          multi_edge;

  always_comb begin
    ones       = '0;
    idx        = '0;
    seen_edge  = 1'b0;
    multi_edge = 1'b0;
    for (int i = 0; i < N; i++) begin
      ones = ones + {{(PW-1){1'b0}}, q[i]};
      if (q[i]) idx = PW'(i);
    end
    // A legal Johnson word has at most one 0/1 boundary between adjacent bits.
    for (int i = 0; i < N - 1; i++) begin
      if (q[i] != q[i+1]) begin
        if (seen_edge) multi_edge = 1'b1;
        seen_edge = 1'b1;
      end
    end
    jn_back = (PW+1)'(2 * N) - {1'b0, ones};
    if (mode == MODE_JOHNSON) begin
      legal = !multi_edge;
      phase = q[N-1] ? jn_back[PW-1:0] : ones;
    end else begin
      legal = (ones == PW'(1));
      phase = idx;
    end
  end

endmodule

// File: rtl/ring_seq_monitor.sv
// Tracks an upstream ring/Johnson counter, declares lock, flags and counts sequence errors.
// Error counter is built only when RING_SEQ_MON_ERR_CNT_EN is defined; otherwise err_cnt reads 0.
module ring_seq_monitor
  import ring_mon_pkg::*;
#(
  parameter  int N        = 4,
  parameter  int LOCK_CNT = 3,
  parameter  int ERR_W    = 8,
  localparam int PW       = $clog2(2 * N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              mode,
  input  logic [N-1:0]      q,
  input  logic              clr_err,
  output logic [PW-1:0]     phase,
  output logic              phase_valid,
  output logic              locked,
  output logic              err_pulse,
  output logic [ERR_W-1:0]  err_cnt,
  output state_e            dbg_state,
  output logic [GCNT_W-1:0] dbg_gcnt
);

  // en is a sample strobe with no backpressure: every cycle en is high, q is consumed.
  state_e              state_q, state_d;
  logic [GCNT_W-1:0]   gcnt_q, gcnt_d;
  logic [PW-1:0]       exp_q, exp_d;
  logic [PW-1:0]       phase_q, phase_d;
  logic                phase_valid_q, phase_valid_d;
  logic                locked_q, locked_d;
  logic                err_pulse_q, err_pulse_d;
  logic                mode_prev_q, mode_prev_d;
  logic                err_event;
  logic                dec_legal;
  logic [PW-1:0]       dec_phase;
  logic [PW-1:0]       last_phase;
  logic [PW-1:0]       next_phase;

  ring_phase_dec #(.N(N)) u_dec (
    .q     (q),
    .mode  (mode),
    .legal (dec_legal),
    .phase (dec_phase)
  );

  always_comb begin
    state_d       = state_q;
    gcnt_d        = gcnt_q;
    exp_d         = exp_q;
    phase_d       = phase_q;
    phase_valid_d = phase_valid_q;
    mode_prev_d   = mode;
    err_event     = 1'b0;
    last_phase    = (mode == MODE_JOHNSON) ? PW'(2 * N - 1) : PW'(N - 1);
    next_phase    = (dec_phase == last_phase) ? '0 : dec_phase + PW'(1);

    if (mode != mode_prev_q) begin
      state_d = ACQ;
      gcnt_d  = '0;
    end else if (en) begin
      phase_valid_d = dec_legal;
      if (dec_legal) phase_d = dec_phase;
      if (state_q == LOCKED) begin
        if (dec_legal && dec_phase == exp_q) begin
          exp_d = next_phase;
        end else begin
          // A legal but wrong sample already counts as the first good sample of reacquisition.
          err_event = 1'b1;
          state_d   = ACQ;
          gcnt_d    = dec_legal ? GCNT_W'(1) : '0;
          if (dec_legal) exp_d = next_phase;
        end
      end else begin
        if (!dec_legal) begin
          gcnt_d = '0;
        end else begin
          exp_d  = next_phase;
          gcnt_d = (gcnt_q == '0 || dec_phase == exp_q) ? gcnt_q + GCNT_W'(1) : GCNT_W'(1);
          if (gcnt_d >= GCNT_W'(LOCK_CNT)) state_d = LOCKED;
        end
      end
    end

    locked_d    = (state_d == LOCKED);
    err_pulse_d = err_event;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ACQ;
      gcnt_q        <= '0;
      exp_q         <= '0;
      phase_q       <= '0;
      phase_valid_q <= 1'b0;
      locked_q      <= 1'b0;
      err_pulse_q   <= 1'b0;
      // Track mode through reset so the first cycle after reset is not seen as a mode change.
      mode_prev_q   <= mode;
    end else begin
      state_q       <= state_d;
      gcnt_q        <= gcnt_d;
      exp_q         <= exp_d;
      phase_q       <= phase_d;
      phase_valid_q <= phase_valid_d;
      locked_q      <= locked_d;
      err_pulse_q   <= err_pulse_d;
      mode_prev_q   <= mode_prev_d;
    end
  end

`ifdef RING_SEQ_MON_ERR_CNT_EN
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_event) begin
      if (clr_err)          err_cnt_d = ERR_W'(1);
      else if (!(&err_cnt_q)) err_cnt_d = err_cnt_q + ERR_W'(1);
    end else if (clr_err) begin
      err_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) err_cnt_q <= '0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`else
  logic unused_clr_err;
  assign unused_clr_err = clr_err;
  assign err_cnt        = '0;
`endif

  assign phase       = phase_q;
  assign phase_valid = phase_valid_q;
  assign locked      = locked_q;
  assign err_pulse   = err_pulse_q;
  assign dbg_state   = state_q;
  assign dbg_gcnt    = gcnt_q;

endmodule

// File: tb/tb_ring_seq_monitor.sv
// Directed table-driven bench for ring_seq_monitor (N=4, LOCK_CNT=3, ERR_W=8).
module tb_ring_seq_monitor;
  import ring_mon_pkg::*;

`ifdef RING_SEQ_MON_ERR_CNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       mode;
  logic [3:0] q;
  logic       clr_err;
  logic [2:0] phase;
  logic       phase_valid;
  logic       locked;
  logic       err_pulse;
  logic [7:0] err_cnt;
  state_e     dbg_state;
  logic [3:0] dbg_gcnt;

  ring_seq_monitor #(.N(4), .LOCK_CNT(3), .ERR_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .mode        (mode),
    .q           (q),
    .clr_err     (clr_err),
    .phase       (phase),
    .phase_valid (phase_valid),
    .locked      (locked),
    .err_pulse   (err_pulse),
    .err_cnt     (err_cnt),
    .dbg_state   (dbg_state),
    .dbg_gcnt    (dbg_gcnt)
  );

  // {phase, phase_valid, locked, err_pulse, err_cnt, gcnt}
  typedef logic [17:0] obs_t;

  typedef struct {
    string      name;
    logic       en;
    logic       mode;
    logic       clr;
    logic [3:0] q;
    logic [2:0] ph;
    logic       pv;
    logic       lk;
    logic       ep;
    logic [7:0] ec;
    logic [3:0] gc;
  } vec_t;

  obs_t exp_q[$];
  vec_t tbl[36];
  int   n_cmp = 0;
  int   n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t exp_obs(input logic [2:0] ph, input logic pv, input logic lk,
                                   input logic ep, input logic [7:0] ec, input logic [3:0] gc);
    logic [7:0] ec_m;
    ec_m = ERR_EN ? ec : 8'd0;
    return {ph, pv, lk, ep, ec_m, gc};
  endfunction

  function automatic vec_t mk(input string nm, input logic e, input logic m, input logic c,
                              input logic [3:0] qq, input logic [2:0] ph, input logic pv,
                              input logic lk, input logic ep, input logic [7:0] ec,
                              input logic [3:0] gc);
    vec_t v;
    v.name = nm; v.en = e; v.mode = m; v.clr = c; v.q = qq;
    v.ph = ph; v.pv = pv; v.lk = lk; v.ep = ep; v.ec = ec; v.gc = gc;
    return v;
  endfunction

  task automatic drive(input logic e, input logic m, input logic c, input logic [3:0] qq);
    en = e; mode = m; clr_err = c; q = qq;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name);
    obs_t e;
    obs_t a;
    e = exp_q.pop_front();
    a = {phase, phase_valid, locked, err_pulse, err_cnt, dbg_gcnt};
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got ph=%0d pv=%0d lk=%0d ep=%0d ec=%0d gc=%0d want ph=%0d pv=%0d lk=%0d ep=%0d ec=%0d gc=%0d",
               name, a[17:15], a[14], a[13], a[12], a[11:4], a[3:0],
               e[17:15], e[14], e[13], e[12], e[11:4], e[3:0]);
    end
  endtask

  task automatic apply(input string name, input logic e, input logic m, input logic c,
                       input logic [3:0] qq, input obs_t expv);
    exp_q.push_back(expv);
    drive(e, m, c, qq);
    check(name);
  endtask

  initial begin
    tbl[0]  = mk("r_s0",        1, 0, 0, 4'b0001, 0, 1, 0, 0, 0, 1);
    tbl[1]  = mk("r_s1",        1, 0, 0, 4'b0010, 1, 1, 0, 0, 0, 2);
    tbl[2]  = mk("r_lock",      1, 0, 0, 4'b0100, 2, 1, 1, 0, 0, 3);
    tbl[3]  = mk("r_p3",        1, 0, 0, 4'b1000, 3, 1, 1, 0, 0, 3);
    tbl[4]  = mk("r_no_en",     0, 0, 0, 4'b0110, 3, 1, 1, 0, 0, 3);
    tbl[5]  = mk("r_wrap0",     1, 0, 0, 4'b0001, 0, 1, 1, 0, 0, 3);
    tbl[6]  = mk("r_illegal",   1, 0, 0, 4'b0110, 0, 0, 0, 1, 1, 0);
    tbl[7]  = mk("r_acq1",      1, 0, 0, 4'b0010, 1, 1, 0, 0, 1, 1);
    tbl[8]  = mk("r_acq2",      1, 0, 0, 4'b0100, 2, 1, 0, 0, 1, 2);
    tbl[9]  = mk("r_relock",    1, 0, 0, 4'b1000, 3, 1, 1, 0, 1, 3);
    tbl[10] = mk("r_hold",      0, 0, 0, 4'b1000, 3, 1, 1, 0, 1, 3);
    tbl[11] = mk("r_skip",      1, 0, 0, 4'b0100, 2, 1, 0, 1, 2, 1);
    tbl[12] = mk("r_acq2b",     1, 0, 0, 4'b1000, 3, 1, 0, 0, 2, 2);
    tbl[13] = mk("r_relock2",   1, 0, 0, 4'b0001, 0, 1, 1, 0, 2, 3);
    tbl[14] = mk("mode_sw",     1, 1, 0, 4'b0001, 0, 1, 0, 0, 2, 0);
    tbl[15] = mk("j_p2",        1, 1, 0, 4'b0011, 2, 1, 0, 0, 2, 1);
    tbl[16] = mk("j_p3",        1, 1, 0, 4'b0111, 3, 1, 0, 0, 2, 2);
    tbl[17] = mk("j_lock4",     1, 1, 0, 4'b1111, 4, 1, 1, 0, 2, 3);
    tbl[18] = mk("j_p5",        1, 1, 0, 4'b1110, 5, 1, 1, 0, 2, 3);
    tbl[19] = mk("j_p6",        1, 1, 0, 4'b1100, 6, 1, 1, 0, 2, 3);
    tbl[20] = mk("j_p7",        1, 1, 0, 4'b1000, 7, 1, 1, 0, 2, 3);
    tbl[21] = mk("j_wrap0",     1, 1, 0, 4'b0000, 0, 1, 1, 0, 2, 3);
    tbl[22] = mk("j_p1",        1, 1, 0, 4'b0001, 1, 1, 1, 0, 2, 3);
    tbl[23] = mk("j_p2b",       1, 1, 0, 4'b0011, 2, 1, 1, 0, 2, 3);
    tbl[24] = mk("j_skip4",     1, 1, 0, 4'b1111, 4, 1, 0, 1, 3, 1);
    tbl[25] = mk("j_acq5",      1, 1, 0, 4'b1110, 5, 1, 0, 0, 3, 2);
    tbl[26] = mk("j_relock6",   1, 1, 0, 4'b1100, 6, 1, 1, 0, 3, 3);
    tbl[27] = mk("j_illegal",   1, 1, 0, 4'b0101, 6, 0, 0, 1, 4, 0);
    tbl[28] = mk("clr_only",    0, 1, 1, 4'b0101, 6, 0, 0, 0, 0, 0);
    tbl[29] = mk("j_p7_acq",    1, 1, 0, 4'b1000, 7, 1, 0, 0, 0, 1);
    tbl[30] = mk("j_reseed",    1, 1, 0, 4'b0011, 2, 1, 0, 0, 0, 1);
    tbl[31] = mk("j_p3b",       1, 1, 0, 4'b0111, 3, 1, 0, 0, 0, 2);
    tbl[32] = mk("j_lock4b",    1, 1, 0, 4'b1111, 4, 1, 1, 0, 0, 3);
    tbl[33] = mk("j_err0",      1, 1, 0, 4'b0000, 0, 1, 0, 1, 1, 1);
    tbl[34] = mk("j_p1c",       1, 1, 0, 4'b0001, 1, 1, 0, 0, 1, 2);
    tbl[35] = mk("j_lock2",     1, 1, 0, 4'b0011, 2, 1, 1, 0, 1, 3);

    // Reset with en asserted: the sample must be ignored.
    rst_n = 1'b0; en = 1'b1; mode = 1'b0; clr_err = 1'b0; q = 4'b0001;
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(exp_obs(0, 0, 0, 0, 0, 0));
    check("reset_vals");
    n_cmp++;
    if (dbg_state !== ACQ) begin
      n_err++;
      $display("FAIL reset_state: got %0d want %0d", dbg_state, ACQ);
    end
    rst_n = 1'b1;

    foreach (tbl[i])
      apply(tbl[i].name, tbl[i].en, tbl[i].mode, tbl[i].clr, tbl[i].q,
            exp_obs(tbl[i].ph, tbl[i].pv, tbl[i].lk, tbl[i].ep, tbl[i].ec, tbl[i].gc));

    // Reset while locked with an error logged; mode/clr_err/en all active in that cycle.
    rst_n = 1'b0;
    apply("reset_locked", 1, 0, 1, 4'b0001, exp_obs(0, 0, 0, 0, 0, 0));
    rst_n = 1'b1;
    apply("post_reset", 1, 0, 0, 4'b0010, exp_obs(1, 1, 0, 0, 0, 1));

    // Drive 256 lock/error rounds to reach and test saturation.
    for (int k = 0; k < 256; k++) begin
      drive(1, 0, 0, 4'b0001);
      drive(1, 0, 0, 4'b0010);
      drive(1, 0, 0, 4'b0100);
      apply($sformatf("sat_err_%0d", k), 1, 0, 0, 4'b0000,
            exp_obs(2, 0, 0, 1, (k < 255) ? 8'(k + 1) : 8'd255, 0));
    end

    drive(1, 0, 0, 4'b0001);
    drive(1, 0, 0, 4'b0010);
    apply("relock_sat", 1, 0, 0, 4'b0100, exp_obs(2, 1, 1, 0, 255, 3));
    apply("clr_with_err", 1, 0, 1, 4'b0000, exp_obs(2, 0, 0, 1, 1, 0));
    apply("clr_alone", 0, 0, 1, 4'b0000, exp_obs(2, 0, 0, 0, 0, 0));
    apply("idle_hold", 0, 0, 0, 4'b1111, exp_obs(2, 0, 0, 0, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
